// File: rtl/addac_mux_arbiter_pkg.sv
// Shared types and constants for the ADDAC DAC-input mux arbiter.
package addac_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT     = 2'd1,
        ACK       = 2'd2,
        WAIT_DROP = 2'd3
    } arb_state_t;

    localparam logic SEL_A   = 1'b0;
    localparam logic SEL_B   = 1'b1;
    localparam int   ADDAC_W = 4;
    localparam int   CNT_W   = 4;

    // On a tie, favour the requester that did not win the previous grant.
    function automatic logic rr_pick(input logic last_grant);
        return (last_grant == SEL_A) ? SEL_B : SEL_A;
    endfunction

endpackage

// File: rtl/addac_mux_arbiter_mux.sv
// Existing fixed 4-bit 2:1 mux in front of the DAC (0 selects a, 1 selects b).
module addac_mux_arbiter_mux
    import addac_arb_pkg::*;
(
    input  logic [ADDAC_W-1:0] a_i,
    input  logic [ADDAC_W-1:0] b_i,
    input  logic               sel_i,
    output logic [ADDAC_W-1:0] y_o
);

    assign y_o = (sel_i == SEL_B) ? b_i : a_i;

endmodule

// File: rtl/addac_mux_arbiter.sv
// Arbitrates requesters A and B (4-phase req/ack) for the shared DAC input mux.
// Optional build macro ADDAC_ARB_FIXED_PRIO_EN: A always wins a tie instead of round-robin.
module addac_mux_arbiter
    import addac_arb_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int HOLD_CYCLES = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    output logic             ack_a,
    output logic             ack_b,
    output logic             mux_sel,
    output logic [WIDTH-1:0] dac_code,
    output logic             dac_valid,
    output logic             busy
);

    generate
        if (WIDTH != ADDAC_W) begin : g_bad_width
            $error("addac_mux_arbiter: WIDTH must equal 4");
        end
        if ((HOLD_CYCLES < 1) || (HOLD_CYCLES > 15)) begin : g_bad_hold
            $error("addac_mux_arbiter: HOLD_CYCLES must be in 1..15");
        end
    endgenerate

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] mux_a_q, mux_a_d;
    logic [WIDTH-1:0] mux_b_q, mux_b_d;
    logic             mux_sel_q, mux_sel_d;
    logic             ack_a_q, ack_a_d;
    logic             ack_b_q, ack_b_d;
    logic             dac_valid_q, dac_valid_d;
    logic             busy_q, busy_d;
    logic             tie_pick_s;
    logic             winner_s;
    logic             granted_req_s;

`ifdef ADDAC_ARB_FIXED_PRIO_EN
    assign tie_pick_s = SEL_A;
`else
    assign tie_pick_s = rr_pick(last_grant_q);
`endif

    // State, datapath and registered-output flops; reset aborts any grant in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            last_grant_q <= SEL_B;
            mux_a_q      <= {WIDTH{1'b0}};
            mux_b_q      <= {WIDTH{1'b0}};
            mux_sel_q    <= SEL_A;
            ack_a_q      <= 1'b0;
            ack_b_q      <= 1'b0;
            dac_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            mux_a_q      <= mux_a_d;
            mux_b_q      <= mux_b_d;
            mux_sel_q    <= mux_sel_d;
            ack_a_q      <= ack_a_d;
            ack_b_q      <= ack_b_d;
            dac_valid_q  <= dac_valid_d;
            busy_q       <= busy_d;
        end
    end

    // Next state: arbitration, code capture and hold countdown.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_grant_d  = last_grant_q;
        mux_a_d       = mux_a_q;
        mux_b_d       = mux_b_q;
        mux_sel_d     = mux_sel_q;
        winner_s      = SEL_A;
        granted_req_s = (last_grant_q == SEL_A) ? req_a : req_b;
        case (state_q)
            IDLE: begin
                if (req_a || req_b) begin
                    if (req_a && req_b) begin
                        winner_s = tie_pick_s;
                    end else if (req_a) begin
                        winner_s = SEL_A;
                    end else begin
                        winner_s = SEL_B;
                    end
                    if (winner_s == SEL_A) begin
                        mux_a_d = data_a;
                    end else begin
                        mux_b_d = data_b;
                    end
                    mux_sel_d    = winner_s;
                    last_grant_d = winner_s;
                    cnt_d        = HOLD_LAST;
                    state_d      = GRANT;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK: begin
                state_d = WAIT_DROP;
            end
            WAIT_DROP: begin
                // Holding here stops a still-raised request from being granted twice.
                if (!granted_req_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_DROP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from the upcoming state so they leave the flops aligned with it.
    always_comb begin
        ack_a_d     = 1'b0;
        ack_b_d     = 1'b0;
        dac_valid_d = 1'b0;
        busy_d      = 1'b0;
        case (state_d)
            IDLE: begin
                busy_d = 1'b0;
            end
            GRANT: begin
                dac_valid_d = 1'b1;
                busy_d      = 1'b1;
            end
            ACK: begin
                busy_d = 1'b1;
                if (last_grant_d == SEL_A) begin
                    ack_a_d = 1'b1;
                end else begin
                    ack_b_d = 1'b1;
                end
            end
            WAIT_DROP: begin
                busy_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign ack_a     = ack_a_q;
    assign ack_b     = ack_b_q;
    assign mux_sel   = mux_sel_q;
    assign dac_valid = dac_valid_q;
    assign busy      = busy_q;

    addac_mux_arbiter_mux u_mux (mux_a_q, mux_b_q, mux_sel, dac_code);

endmodule

// File: tb/tb_addac_mux_arbiter.sv
// Self-checking bench for addac_mux_arbiter: grant-timeline reference model plus directed cases.
module tb_addac_mux_arbiter;
    import addac_arb_pkg::*;

    localparam int HOLD = 3;
`ifdef ADDAC_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic       req_a  = 1'b0;
    logic       req_b  = 1'b0;
    logic [3:0] data_a = 4'h0;
    logic [3:0] data_b = 4'h0;
    logic       ack_a, ack_b, mux_sel, dac_valid, busy;
    logic [3:0] dac_code;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    addac_mux_arbiter #(.WIDTH(4), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .data_a(data_a), .req_b(req_b), .data_b(data_b),
        .ack_a(ack_a), .ack_b(ack_b), .mux_sel(mux_sel), .dac_code(dac_code),
        .dac_valid(dac_valid), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a grant is a timestamp g; valid for H cycles, ack on cycle g+H,
    // and the requester is released on the first edge >= g+H+2 where its req is low.
    bit         m_active;
    bit         m_last;
    bit         m_sel;
    int         m_g;
    int         edge_n;
    logic [3:0] m_reg [2];

    function automatic bit pick(input bit a, input bit b, input bit last);
        if (a && b) return FIXED ? 1'b0 : !last;
        return b;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active <= 1'b0;
            m_last   <= 1'b1;
            m_sel    <= 1'b0;
            m_g      <= 0;
            edge_n   <= 0;
            m_reg[0] <= 4'h0;
            m_reg[1] <= 4'h0;
        end else begin
            edge_n <= edge_n + 1;
            if (m_active) begin
                if ((edge_n + 1 >= m_g + HOLD + 2) && !(m_last ? req_b : req_a))
                    m_active <= 1'b0;
            end else if (req_a || req_b) begin
                m_active <= 1'b1;
                m_g      <= edge_n + 1;
                m_last   <= pick(req_a, req_b, m_last);
                m_sel    <= pick(req_a, req_b, m_last);
                if (pick(req_a, req_b, m_last)) m_reg[1] <= data_b;
                else                            m_reg[0] <= data_a;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        automatic int ph;
        if (reset) begin
            ph = edge_n - m_g;
            chk("busy",      32'(busy),      32'(m_active));
            chk("dac_valid", 32'(dac_valid), 32'(m_active && (ph < HOLD)));
            chk("ack_a",     32'(ack_a),     32'(m_active && (ph == HOLD) && !m_last));
            chk("ack_b",     32'(ack_b),     32'(m_active && (ph == HOLD) && m_last));
            chk("mux_sel",   32'(mux_sel),   32'(m_sel));
            chk("dac_code",  32'(dac_code),  32'(m_reg[m_sel]));
        end
    end

    // Grant log: selection and code at each rising edge of dac_valid.
    logic       pv = 1'b0;
    bit         gsel  [$];
    logic [3:0] gcode [$];
    always @(negedge clk) begin
        if (reset && dac_valid && !pv) begin
            gsel.push_back(mux_sel);
            gcode.push_back(dac_code);
        end
        pv <= reset ? dac_valid : 1'b0;
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        gsel.delete();
        gcode.delete();
    endtask

    initial begin
        int         vcnt;
        int         ack_c;
        bit         ak_a;
        bit         ak_b;
        logic [3:0] exp_seq;

        do_reset();
        step();
        chk("rst_dac_code",  32'(dac_code),  32'h0);
        chk("rst_mux_sel",   32'(mux_sel),   32'h0);
        chk("rst_busy",      32'(busy),      32'h0);
        chk("rst_dac_valid", 32'(dac_valid), 32'h0);

        // Single A request, data changed mid-grant.
        req_a = 1'b1; data_a = 4'hA; vcnt = 0; ack_c = 0;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 2) data_a = 4'h7;
            if (dac_valid) vcnt++;
            if (ack_a) begin ack_c = c; req_a = 1'b0; end
            if (c <= 3) chk("a_code_hold", 32'(dac_code), 32'hA);
        end
        chk("a_valid_cycles", 32'(vcnt), 32'd3);
        chk("a_ack_cycle",    32'(ack_c), 32'd4);
        chk("a_code_after",   32'(dac_code), 32'hA);
        chk("a_mux_sel",      32'(mux_sel), 32'h0);

        // Single B, req held two cycles past ack.
        gsel.delete(); gcode.delete();
        req_b = 1'b1; data_b = 4'h5; ack_c = 0;
        for (int c = 1; c <= 14; c++) begin
            step();
            if (ack_b) ack_c = c;
            if ((ack_c != 0) && ((c == ack_c + 1) || (c == ack_c + 2))) chk("b_wait_busy", 32'(busy), 32'h1);
            if ((ack_c != 0) && (c == ack_c + 2)) req_b = 1'b0;
        end
        chk("b_ack_cycle", 32'(ack_c), 32'd4);
        chk("b_grants",    32'(gsel.size()), 32'd1);
        if (gsel.size() > 0) begin
            chk("b_code", 32'(gcode[0]), 32'h5);
            chk("b_sel",  32'(gsel[0]),  32'h1);
        end

        // Async reset during GRANT.
        req_a = 1'b1; data_a = 4'h9;
        step(); step();
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_busy",     32'(busy),      32'h0);
        chk("abort_valid",    32'(dac_valid), 32'h0);
        chk("abort_ack_a",    32'(ack_a),     32'h0);
        chk("abort_dac_code", 32'(dac_code),  32'h0);
        chk("abort_mux_sel",  32'(mux_sel),   32'h0);
        req_a = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        ack_c = 0;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (ack_a || ack_b) ack_c++;
        end
        chk("abort_no_ack", 32'(ack_c), 32'd0);

        // Tie right after reset.
        do_reset();
        req_a = 1'b1; req_b = 1'b1; data_a = 4'h3; data_b = 4'hC;
        for (int c = 1; c <= 24; c++) begin
            step();
            if (ack_a) req_a = 1'b0;
            if (ack_b) req_b = 1'b0;
        end
        chk("tie_grants", 32'(gsel.size()), 32'd2);
        if (gsel.size() >= 2) begin
            chk("tie_code0", 32'(gcode[0]), 32'h3);
            chk("tie_code1", 32'(gcode[1]), 32'hC);
            chk("tie_sel0",  32'(gsel[0]),  32'h0);
            chk("tie_sel1",  32'(gsel[1]),  32'h1);
        end
        chk("tie_mux_a_reg", 32'(dut.mux_a_q), 32'h3);

        // Four consecutive ties.
        do_reset();
        req_a = 1'b1; req_b = 1'b1; data_a = 4'h1; data_b = 4'h2;
        for (int c = 1; c <= 60; c++) begin
            step();
            if (ack_a) req_a = 1'b0;
            if (ack_b) req_b = 1'b0;
            if (!busy && (gsel.size() < 4)) begin req_a = 1'b1; req_b = 1'b1; end
        end
        exp_seq = FIXED ? 4'b0000 : 4'b1010;
        chk("rep_grants", 32'(gsel.size() >= 4), 32'h1);
        for (int i = 0; i < 4; i++) begin
            if (i < gsel.size()) chk("rep_tie_sel", 32'(gsel[i]), 32'(exp_seq[i]));
        end

        // Randomized 4-phase requesters with occasional early drops and resets.
        do_reset();
        ak_a = 1'b0; ak_b = 1'b0;
        repeat (3000) begin
            step();
            if (ack_a) ak_a = 1'b1;
            if (ack_b) ak_b = 1'b1;
            if (req_a) begin
                if (ak_a ? ($urandom_range(1, 0) == 0) : ($urandom_range(39, 0) == 0)) req_a = 1'b0;
                else if ($urandom_range(7, 0) == 0) data_a = 4'($urandom);
            end else if ($urandom_range(2, 0) == 0) begin
                req_a = 1'b1; data_a = 4'($urandom); ak_a = 1'b0;
            end
            if (req_b) begin
                if (ak_b ? ($urandom_range(1, 0) == 0) : ($urandom_range(39, 0) == 0)) req_b = 1'b0;
                else if ($urandom_range(7, 0) == 0) data_b = 4'($urandom);
            end else if ($urandom_range(2, 0) == 0) begin
                req_b = 1'b1; data_b = 4'($urandom); ak_b = 1'b0;
            end
            if ($urandom_range(399, 0) == 0) begin
                #2 reset = 1'b0;
                req_a = 1'b0; req_b = 1'b0; ak_a = 1'b0; ak_b = 1'b0;
                @(negedge clk);
                reset = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
